// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter
// Description : Two-requester round-robin arbiter that drives the select of a
//               shared 2:1 data mux and moves granted beats into a registered
//               valid/ready output stage. Grants are limited to BURST beats
//               before re-arbitration is forced.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ready_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready_b,
  output logic             ctrl,
  output logic             owner_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Beat counter only ever reaches BURST-1; the extra bit keeps BURST=1 legal.
  localparam int CNT_W = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Side that last held the grant: 0 = A, 1 = B.
  logic             last_q, last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             w_space;
  logic             w_accept_a;
  logic             w_accept_b;
  logic             w_accept;
  logic             w_burst_end;
  logic [WIDTH-1:0] w_mux_data;

  // Output decodes come straight from registered state so the mux select
  // never glitches and has no path from out_ready.
  assign ctrl      = (state_q == ST_GRANT_B);
  assign owner_vld = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Handshake: a beat may enter the output stage when it is empty or being drained.
  always_comb begin
    w_space     = !out_valid_q || out_ready;
    w_accept_a  = (state_q == ST_GRANT_A) && req_a && w_space;
    w_accept_b  = (state_q == ST_GRANT_B) && req_b && w_space;
    w_accept    = w_accept_a || w_accept_b;
    w_burst_end = (cnt_q == C_CNT_LAST);
    w_mux_data  = ctrl ? data_b : data_a;
    ready_a     = w_accept_a;
    ready_b     = w_accept_b;
  end

  // Arbitration FSM: next state, burst counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = last_q ? ST_GRANT_A : ST_GRANT_B;
        end else if (req_a) begin
          state_d = ST_GRANT_A;
        end else if (req_b) begin
          state_d = ST_GRANT_B;
        end
      end
      ST_GRANT_A: begin
        if (w_accept_a) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
        if (!req_a || (w_accept_a && w_burst_end)) begin
          cnt_d  = '0;
          last_d = 1'b0;
          if (req_b) begin
            state_d = ST_GRANT_B;
          end else if (req_a) begin
            state_d = ST_GRANT_A;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GRANT_B: begin
        if (w_accept_b) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
        if (!req_b || (w_accept_b && w_burst_end)) begin
          cnt_d  = '0;
          last_d = 1'b1;
          if (req_a) begin
            state_d = ST_GRANT_A;
          end else if (req_b) begin
            state_d = ST_GRANT_B;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage: load on accept, otherwise drain when the consumer takes it.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (w_accept) begin
      out_data_d  = w_mux_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset leaves B as last owner so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire
